xor_gate_32bit: RTL and testbench

Bitwise 32-bit XOR unit for the datapath's combinational logic library. It drives a zero-latency combinational XOR output. It also provides a registered result path that adds Hamming distance and an all-zero flag, for pipelined consumers such as compare and checksum stages. The combinational output and the registered path share the same operands.

---
 rtl/xor_pkg.sv | 17 +
 rtl/popcount32.sv | 39 +++
 rtl/xor_gate_32bit.sv | 90 +++++++++
 tb/tb_xor_gate_32bit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_pkg
//  Description : Shared constants and types for the 32-bit XOR unit and its
//                popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int HD_W          = $clog2(WIDTH_DEFAULT + 1);

    // Native operand word at the default width
    typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage : xor_pkg
`default_nettype wire

// File: rtl/popcount32.sv
`default_nettype none
// ============================================================================
//  Module      : popcount32
//  Description : Combinational popcount of a 32-bit word built as a balanced
//                pairwise adder tree (1 -> 2 -> 3 -> 4 -> 5 -> 6-bit sums).
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount32 (
    input  logic [31:0] i_bits,
    output logic [5:0]  o_count
);

    // Each level halves the node count and widens each partial sum by one
    // bit, so no level can overflow.
    logic [1:0] w_s1 [0:15];
    logic [2:0] w_s2 [0:7];
    logic [3:0] w_s3 [0:3];
    logic [4:0] w_s4 [0:1];

    for (genvar i = 0; i < 16; i++) begin : g_lvl1
        assign w_s1[i] = {1'b0, i_bits[2*i]} + {1'b0, i_bits[2*i+1]};
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl2
        assign w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_lvl3
        assign w_s3[i] = {1'b0, w_s2[2*i]} + {1'b0, w_s2[2*i+1]};
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl4
        assign w_s4[i] = {1'b0, w_s3[2*i]} + {1'b0, w_s3[2*i+1]};
    end

    assign o_count = {1'b0, w_s4[0]} + {1'b0, w_s4[1]};

endmodule : popcount32
`default_nettype wire

// File: rtl/xor_gate_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : xor_gate_32bit
//  Description : Bitwise XOR with a zero-latency combinational output and a
//                one-cycle registered path carrying the XOR word, its Hamming
//                weight and an all-zero (a == b) flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_gate_32bit
    import xor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             y,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             y_q,
    output logic [$clog2(WIDTH+1)-1:0]   hd_q,
    output logic                         zero_q
);

    localparam int c_HD_W   = $clog2(WIDTH + 1);
    // Operands wider than 32 bits are split into 32-bit chunks, each with its
    // own popcount tree; at the default width this is a single instance.
    localparam int c_NCHUNK = (WIDTH + 31) / 32;
    localparam int c_PAD_W  = c_NCHUNK * 32;

    logic [WIDTH-1:0]   w_y;
    logic [c_PAD_W-1:0] w_y_pad;
    logic [5:0]         w_cnt [0:c_NCHUNK-1];
    logic [c_HD_W-1:0]  w_hd;
    logic               w_zero;

    logic               r_valid;
    logic [WIDTH-1:0]   r_y;
    logic [c_HD_W-1:0]  r_hd;
    logic               r_zero;

    // Pure bitwise XOR: an X on one input bit only affects that output bit.
    assign w_y = a ^ b;
    assign y   = w_y;

    // Zero-extend to a whole number of chunks; padding bits add nothing.
    assign w_y_pad = c_PAD_W'(w_y);

    for (genvar c = 0; c < c_NCHUNK; c++) begin : g_chunk
        popcount32 u_popcount (
            .i_bits  (w_y_pad[32*c +: 32]),
            .o_count (w_cnt[c])
        );
    end

    // Combine chunk counts; total never exceeds WIDTH so c_HD_W bits suffice.
    always_comb begin
        w_hd = '0;
        for (int c = 0; c < c_NCHUNK; c++) begin
            w_hd = w_hd + c_HD_W'(w_cnt[c]);
        end
    end

    assign w_zero = ~|w_y;

    // Single result stage: reset wins over capture, idle cycles hold data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_hd    <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y    <= w_y;
                r_hd   <= w_hd;
                r_zero <= w_zero;
            end
        end
    end

    assign out_valid = r_valid;
    assign y_q       = r_y;
    assign hd_q      = r_hd;
    assign zero_q    = r_zero;

endmodule : xor_gate_32bit
`default_nettype wire

// File: tb/tb_xor_gate_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_gate_32bit
//  Description : Directed self-checking bench for xor_gate_32bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_gate_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic [31:0] y;
    logic        out_valid;
    logic [31:0] y_q;
    logic [5:0]  hd_q;
    logic        zero_q;

    int total;
    int bad;

    xor_gate_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid),
        .y_q       (y_q),
        .hd_q      (hd_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset with a valid pair present: registered path cleared, y still live.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h0F0F0F0F;
        @(posedge clk); @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (y_q !== 32'h0) begin bad++; $display("FAIL reset_yq got=%h exp=00000000", y_q); end
        total++; if (hd_q !== 6'd0) begin bad++; $display("FAIL reset_hd got=%0d exp=0", hd_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero_q); end
        total++; if (y !== 32'hD1A2B1E0) begin bad++; $display("FAIL reset_y got=%h exp=d1a2b1e0", y); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_zero_zero();
        @(negedge clk);
        a = 32'h0; b = 32'h0; in_valid = 1'b1; #1;
        total++; if (y !== 32'h0) begin bad++; $display("FAIL zz_y got=%h exp=00000000", y); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zz_valid got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'h0) begin bad++; $display("FAIL zz_yq got=%h exp=00000000", y_q); end
        total++; if (hd_q !== 6'd0) begin bad++; $display("FAIL zz_hd got=%0d exp=0", hd_q); end
        total++; if (zero_q !== 1'b1) begin bad++; $display("FAIL zz_zero got=%b exp=1", zero_q); end
    endtask

    task automatic test_ones_ones();
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1; #1;
        total++; if (y !== 32'h0) begin bad++; $display("FAIL oo_y got=%h exp=00000000", y); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL oo_valid got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'h0) begin bad++; $display("FAIL oo_yq got=%h exp=00000000", y_q); end
        total++; if (hd_q !== 6'd0) begin bad++; $display("FAIL oo_hd got=%0d exp=0", hd_q); end
        total++; if (zero_q !== 1'b1) begin bad++; $display("FAIL oo_zero got=%b exp=1", zero_q); end
    endtask

    // Two consecutive valid pairs give two consecutive full-weight results.
    task automatic test_back_to_back();
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h0; in_valid = 1'b1; #1;
        total++; if (y !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_y0 got=%h exp=ffffffff", y); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_yq0 got=%h exp=ffffffff", y_q); end
        total++; if (hd_q !== 6'd32) begin bad++; $display("FAIL b2b_hd0 got=%0d exp=32", hd_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL b2b_zero0 got=%b exp=0", zero_q); end
        @(negedge clk);
        a = 32'h0; b = 32'hFFFFFFFF; #1;
        total++; if (y !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_y1 got=%h exp=ffffffff", y); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_yq1 got=%h exp=ffffffff", y_q); end
        total++; if (hd_q !== 6'd32) begin bad++; $display("FAIL b2b_hd1 got=%0d exp=32", hd_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL b2b_zero1 got=%b exp=0", zero_q); end
    endtask

    task automatic test_mixed();
        @(negedge clk);
        a = 32'h12345678; b = 32'hABCDEF01; in_valid = 1'b1; #1;
        total++; if (y !== 32'hB9F9B979) begin bad++; $display("FAIL mix_y got=%h exp=b9f9b979", y); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mix_valid got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'hB9F9B979) begin bad++; $display("FAIL mix_yq got=%h exp=b9f9b979", y_q); end
        total++; if (hd_q !== 6'd21) begin bad++; $display("FAIL mix_hd got=%0d exp=21", hd_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL mix_zero got=%b exp=0", zero_q); end
    endtask

    // Idle cycles: valid drops, captured data holds, y keeps following inputs.
    task automatic test_hold();
        @(negedge clk);
        a = 32'h00000001; b = 32'h00000001; in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
        total++; if (y_q !== 32'hB9F9B979) begin bad++; $display("FAIL hold_yq got=%h exp=b9f9b979", y_q); end
        total++; if (hd_q !== 6'd21) begin bad++; $display("FAIL hold_hd got=%0d exp=21", hd_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL hold_zero got=%b exp=0", zero_q); end
        total++; if (y !== 32'h0) begin bad++; $display("FAIL hold_y got=%h exp=00000000", y); end
        @(posedge clk); #1;
        total++; if (hd_q !== 6'd21) begin bad++; $display("FAIL hold2_hd got=%0d exp=21", hd_q); end
    endtask

    // Reset between captures drops the pair on the reset edge, then resumes.
    task automatic test_reset_midstream();
        @(negedge clk);
        a = 32'h80000001; b = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (hd_q !== 6'd2) begin bad++; $display("FAIL mid_pre_hd got=%0d exp=2", hd_q); end
        @(negedge clk);
        rst = 1'b1; a = 32'hFFFF0000; b = 32'h0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        total++; if (y_q !== 32'h0) begin bad++; $display("FAIL mid_rst_yq got=%h exp=00000000", y_q); end
        total++; if (hd_q !== 6'd0) begin bad++; $display("FAIL mid_rst_hd got=%0d exp=0", hd_q); end
        total++; if (y !== 32'hFFFF0000) begin bad++; $display("FAIL mid_rst_y got=%h exp=ffff0000", y); end
        @(negedge clk);
        rst = 1'b0; a = 32'h0F0F0F0F; b = 32'h0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_post_valid got=%b exp=1", out_valid); end
        total++; if (y_q !== 32'h0F0F0F0F) begin bad++; $display("FAIL mid_post_yq got=%h exp=0f0f0f0f", y_q); end
        total++; if (hd_q !== 6'd16) begin bad++; $display("FAIL mid_post_hd got=%0d exp=16", hd_q); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_end_valid got=%b exp=0", out_valid); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        test_reset();
        test_zero_zero();
        test_ones_ones();
        test_back_to_back();
        test_mixed();
        test_hold();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_xor_gate_32bit
`default_nettype wire
